// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one parallel-load serial shifter between NCH requesters.
// Each grant loads one channel's word into the shifter and frames its WIDTH+1 serial bits.
module shift_sched #(
    parameter int WIDTH = 30,
    parameter int NCH   = 2,
    parameter int GAP   = 4,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int BW   = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*(WIDTH+1)-1:0] req_data,
    output logic [NCH-1:0]           req_ack,
    output logic                     sr_load,
    output logic [WIDTH:0]           sr_din,
    output logic                     frame,
    output logic                     frame_start,
    output logic [CW-1:0]            chan,
    output logic                     busy
);

    // Handshake: a requester holds req_valid[i] and its word stable until it sees the
    // one-cycle req_ack[i]; req_valid is only sampled in IDLE, so withdrawing it before
    // the grant is legal and changes while busy are ignored.

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   ptr_q;
    logic [BW-1:0]   bitcnt_q;
    logic [7:0]      gapcnt_q;
    logic [NCH-1:0]  ack_q;
    logic            load_q;
    logic [WIDTH:0]  din_q;
    logic            frame_q;
    logic            fstart_q;
    logic [CW-1:0]   chan_q;
    logic            busy_q;

    logic            gnt_found_d;
    logic [CW-1:0]   gnt_idx_d;
    logic [WIDTH:0]  gnt_word_d;
    logic [NCH-1:0]  gnt_onehot_d;
    logic [CW:0]     cand;

    // Search upward from ptr+1 with wrap, so the last granted channel comes last.
    always_comb begin
        gnt_found_d = 1'b0;
        gnt_idx_d   = '0;
        cand        = '0;
        for (int s = 1; s <= NCH; s++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(s);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (!gnt_found_d && req_valid[cand[CW-1:0]]) begin
                gnt_found_d = 1'b1;
                gnt_idx_d   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        gnt_word_d   = '0;
        gnt_onehot_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (gnt_idx_d == CW'(k)) begin
                gnt_word_d      = req_data[k*(WIDTH+1) +: (WIDTH+1)];
                gnt_onehot_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= CW'(NCH - 1);
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            ack_q    <= '0;
            load_q   <= 1'b0;
            din_q    <= '0;
            frame_q  <= 1'b0;
            fstart_q <= 1'b0;
            chan_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_found_d) begin
                        load_q  <= 1'b1;
                        din_q   <= gnt_word_d;
                        ack_q   <= gnt_onehot_d;
                        chan_q  <= gnt_idx_d;
                        ptr_q   <= gnt_idx_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The shifter captures din at this edge; first bit appears next cycle.
                    load_q   <= 1'b0;
                    ack_q    <= '0;
                    frame_q  <= 1'b1;
                    fstart_q <= 1'b1;
                    bitcnt_q <= '0;
                    state_q  <= S_SHIFT;
                end
                S_SHIFT: begin
                    fstart_q <= 1'b0;
                    if (bitcnt_q == BW'(WIDTH)) begin
                        frame_q <= 1'b0;
                        if (GAP == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            gapcnt_q <= '0;
                            state_q  <= S_GAP;
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gapcnt_q == 8'(GAP - 1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gapcnt_q <= gapcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack     = ack_q;
    assign sr_load     = load_q;
    assign sr_din      = din_q;
    assign frame       = frame_q;
    assign frame_start = fstart_q;
    assign chan        = chan_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: two instances (2 channels / GAP=4 and 1 channel / GAP=0) driven
// by random requesters and checked every cycle against a grant-timeline reference model.
module tb_shift_sched;

    localparam int W    = 30;
    localparam int N0   = 2;
    localparam int G0   = 4;
    localparam int N1   = 1;
    localparam int G1   = 0;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [2];
    logic [7:0] vld   [2];
    logic [W:0] wrd   [2][8];

    logic                  rst0;
    logic [N0-1:0]         v0;
    logic [N0*(W+1)-1:0]   data0;
    logic [N0-1:0]         ack0;
    logic                  load0;
    logic [W:0]            din0;
    logic                  frame0;
    logic                  fs0;
    logic [0:0]            chan0;
    logic                  busy0;

    logic                  rst1;
    logic [N1-1:0]         v1;
    logic [N1*(W+1)-1:0]   data1;
    logic [N1-1:0]         ack1;
    logic                  load1;
    logic [W:0]            din1;
    logic                  frame1;
    logic                  fs1;
    logic [0:0]            chan1;
    logic                  busy1;

    assign rst0  = rst_v[0];
    assign v0    = vld[0][N0-1:0];
    assign data0 = {wrd[0][1], wrd[0][0]};
    assign rst1  = rst_v[1];
    assign v1    = vld[1][N1-1:0];
    assign data1 = wrd[1][0];

    shift_sched #(.WIDTH(W), .NCH(N0), .GAP(G0)) u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(v0), .req_data(data0), .req_ack(ack0),
        .sr_load(load0), .sr_din(din0), .frame(frame0), .frame_start(fs0),
        .chan(chan0), .busy(busy0)
    );

    shift_sched #(.WIDTH(W), .NCH(N1), .GAP(G1)) u_dut1 (
        .clk(clk), .rst(rst1), .req_valid(v1), .req_data(data1), .req_ack(ack1),
        .sr_load(load1), .sr_din(din1), .frame(frame1), .frame_start(fs1),
        .chan(chan1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cur_k = 0;
    bit rst_done = 1'b0;

    // Reference: a grant at edge 0 gives LOAD after edge 0, frame bits after edges
    // 1..W+1, busy through edge W+1+GAP, next arbitration at edge W+3+GAP.
    int         nch      [2];
    int         gap      [2];
    int         m_act    [2];
    int         m_d      [2];
    int         m_g      [2];
    int         m_ptr    [2];
    int         m_frames [2];
    int         o_frames [2];
    logic       m_rst    [2];
    logic [W:0] m_word   [2];
    logic [W:0] sh       [2];
    logic [W:0] p_din    [2];
    logic       p_load   [2];
    logic [7:0] ack_seen [2];

    logic [7:0] o_ack;
    logic       o_load;
    logic [W:0] o_din;
    logic       o_frame;
    logic       o_fs;
    logic [7:0] o_chan;
    logic       o_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL u%0d %s cyc=%0d got=%0h exp=%0h", cur_k, tag, cyc, got, exp);
        end
    endtask

    task automatic grab(input int k);
        if (k == 0) begin
            o_ack = 8'(ack0); o_load = load0; o_din = din0; o_frame = frame0;
            o_fs = fs0; o_chan = 8'(chan0); o_busy = busy0;
        end else begin
            o_ack = 8'(ack1); o_load = load1; o_din = din1; o_frame = frame1;
            o_fs = fs1; o_chan = 8'(chan1); o_busy = busy1;
        end
    endtask

    task automatic model_step(input int k);
        int c;
        m_rst[k] = rst_v[k];
        if (rst_v[k]) begin
            m_act[k] = 0;
            m_d[k]   = 0;
            m_ptr[k] = nch[k] - 1;
        end else begin
            if (m_act[k] != 0) m_d[k]++;
            if (m_act[k] == 0 || m_d[k] >= W + 3 + gap[k]) begin
                m_act[k] = 0;
                for (int s = 1; s <= nch[k]; s++) begin
                    c = (m_ptr[k] + s) % nch[k];
                    if (m_act[k] == 0 && vld[k][c]) begin
                        m_act[k]  = 1;
                        m_d[k]    = 0;
                        m_g[k]    = c;
                        m_ptr[k]  = c;
                        m_word[k] = wrd[k][c];
                    end
                end
            end
        end
    endtask

    task automatic compare(input int k);
        bit ld_e, fr_e, bz_e;
        if (p_load[k]) sh[k] = p_din[k];
        else           sh[k] = sh[k] << 1;
        grab(k);
        ld_e = (m_act[k] != 0) && (m_d[k] == 0);
        fr_e = (m_act[k] != 0) && (m_d[k] >= 1) && (m_d[k] <= W + 1);
        bz_e = (m_act[k] != 0) && (m_d[k] <= W + 1 + gap[k]);
        check_eq("req_ack", o_ack, ld_e ? (8'd1 << m_g[k]) : 8'd0);
        check_eq("sr_load", o_load, ld_e);
        check_eq("frame", o_frame, fr_e);
        check_eq("frame_start", o_fs, (m_act[k] != 0) && (m_d[k] == 1));
        check_eq("busy", o_busy, bz_e);
        if (ld_e) check_eq("sr_din", o_din, m_word[k]);
        if (fr_e) begin
            check_eq("chan", o_chan, m_g[k]);
            check_eq("sout", sh[k][W], m_word[k][W - (m_d[k] - 1)]);
        end
        if (m_rst[k]) begin
            check_eq("rst_sr_din", o_din, 0);
            check_eq("rst_chan", o_chan, 0);
        end
        if ((m_act[k] != 0) && (m_d[k] == 1)) m_frames[k]++;
        if (o_fs) o_frames[k]++;
        ack_seen[k] = o_ack;
        p_load[k]   = o_load;
        p_din[k]    = o_din;
    endtask

    task automatic drive0();
        logic r;
        r = (cyc < 2) || (cyc == 60);
        if (!rst_done && cyc >= 250 && m_act[0] != 0 && m_d[0] == 11 && !m_rst[0]) begin
            r = 1'b1;
            rst_done = 1'b1;
        end
        if (cyc >= 400 && $urandom_range(0, 299) == 0) r = 1'b1;
        rst_v[0] = r;
        for (int c = 0; c < N0; c++) begin
            if (ack_seen[0][c]) begin
                if (cyc < 60 || (cyc >= 400 && $urandom_range(0, 1) == 0)) begin
                    vld[0][c] = 1'b0;
                end else begin
                    wrd[0][c] = (W+1)'($urandom);
                    vld[0][c] = 1'b1;
                end
            end else if (cyc < 60) begin
                if (cyc == 2 && c == 0) begin
                    wrd[0][0] = 31'h4000_0001;
                    vld[0][0] = 1'b1;
                end
            end else if (cyc < 400) begin
                if (!vld[0][c]) begin
                    wrd[0][c] = (W+1)'($urandom);
                    vld[0][c] = 1'b1;
                end
            end else if (!vld[0][c]) begin
                if ($urandom_range(0, 2) == 0) begin
                    wrd[0][c] = (W+1)'($urandom);
                    vld[0][c] = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                vld[0][c] = 1'b0;
            end
        end
    endtask

    task automatic drive1();
        rst_v[1] = (cyc < 2) || (cyc >= 100 && $urandom_range(0, 499) == 0);
        if (ack_seen[1][0] || (cyc >= 3 && !vld[1][0])) begin
            wrd[1][0] = (W+1)'($urandom);
            vld[1][0] = 1'b1;
        end
    endtask

    initial begin
        nch[0] = N0; gap[0] = G0;
        nch[1] = N1; gap[1] = G1;
        for (int k = 0; k < 2; k++) begin
            rst_v[k]    = 1'b1;
            vld[k]      = '0;
            for (int c = 0; c < 8; c++) wrd[k][c] = '0;
            m_act[k]    = 0;
            m_d[k]      = 0;
            m_g[k]      = 0;
            m_ptr[k]    = nch[k] - 1;
            m_frames[k] = 0;
            o_frames[k] = 0;
            m_rst[k]    = 1'b0;
            m_word[k]   = '0;
            sh[k]       = '0;
            p_din[k]    = '0;
            p_load[k]   = 1'b0;
            ack_seen[k] = '0;
        end
        repeat (NCYC) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                cur_k = k;
                model_step(k);
                compare(k);
            end
            cyc++;
            drive0();
            drive1();
        end
        for (int k = 0; k < 2; k++) begin
            cur_k = k;
            check_eq("frame_count", o_frames[k], m_frames[k]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
